noc_fifo_pkt_arbiter: RTL and testbench



---
 rtl/noc_fifo_pkt_arbiter_pkg.sv | 22 ++
 rtl/noc_fifo_pkt_arbiter_rr_pick.sv | 32 +++
 rtl/noc_fifo_pkt_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_noc_fifo_pkt_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_fifo_pkt_arbiter_pkg.sv
// Shared constants and types for the packet-aware FIFO arbiter.
// Optional statistics block is enabled by NOC_FIFO_ARB_STATS_EN in the top.
package noc_fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  // Register offsets relative to SR_ARB_BASE
  localparam int ARB_MASK_OFS    = 0;
  localparam int ARB_QUANTUM_OFS = 1;
  localparam int ARB_STATS_OFS   = 2;

  localparam int ARB_QUANTUM_W = 8;

  // A programmed quantum of zero behaves as one packet per grant
  function automatic logic [ARB_QUANTUM_W-1:0] eff_quantum(input logic [ARB_QUANTUM_W-1:0] q);
    return (q == '0) ? {{(ARB_QUANTUM_W-1){1'b0}}, 1'b1} : q;
  endfunction

endpackage

// File: rtl/noc_fifo_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after i_ptr,
// wrapping around, with i_ptr itself checked last.
module rr_pick #(
  parameter int NUM_INPUTS = 4,
  parameter int SW         = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] i_eligible,
  input  logic [SW-1:0]         i_ptr,
  output logic [SW-1:0]         o_grant,
  output logic                  o_any
);

  logic found;
  int   idx;

  // Scan ptr+1 .. ptr+NUM_INPUTS modulo NUM_INPUTS and keep the first hit
  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_INPUTS; i++) begin
      idx = (int'(i_ptr) + i) % NUM_INPUTS;
      if (!found && i_eligible[idx[SW-1:0]]) begin
        found   = 1'b1;
        o_grant = idx[SW-1:0];
      end
    end
  end

  assign o_any = |i_eligible;

endmodule

// File: rtl/noc_fifo_pkt_arbiter.sv
// Packet-aware round-robin arbiter feeding a shared {tlast,tdata} FIFO.
// One input owns the output for up to `quantum` whole packets; beats of
// different packets are never interleaved.
// Define NOC_FIFO_ARB_STATS_EN to add per-input packet/beat counters and
// the rb_data readback port (stats select at SR_ARB_BASE+2).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid & masked-in inputs (1 bubble)
// PASS  | granted input passed straight through to the FIFO
module noc_fifo_pkt_arbiter
  import noc_fifo_arb_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int WIDTH       = 32,
  parameter int SR_ARB_BASE = 129
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          set_stb,
  input  logic [7:0]                    set_addr,
  input  logic [31:0]                   set_data,
  input  logic [NUM_INPUTS*WIDTH-1:0]   i_tdata,
  input  logic [NUM_INPUTS-1:0]         i_tlast,
  input  logic [NUM_INPUTS-1:0]         i_tvalid,
  output logic [NUM_INPUTS-1:0]         i_tready,
  output logic [WIDTH-1:0]              o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          o_tready,
  output logic [$clog2(NUM_INPUTS)-1:0] o_src,
  output logic                          busy
`ifdef NOC_FIFO_ARB_STATS_EN
  ,
  output logic [63:0]                   rb_data
`endif
);

  localparam int              SW       = $clog2(NUM_INPUTS);
  localparam logic [SW-1:0]   LAST_IDX = SW'(NUM_INPUTS - 1);
  localparam logic [0:0]      S_IDLE   = IDLE;
  localparam logic [0:0]      S_PASS   = PASS;
  localparam logic [7:0]      A_MASK   = 8'(SR_ARB_BASE + ARB_MASK_OFS);
  localparam logic [7:0]      A_QUANT  = 8'(SR_ARB_BASE + ARB_QUANTUM_OFS);

  logic [0:0]               r_state;
  logic [SW-1:0]            r_src;
  logic [SW-1:0]            r_ptr;
  logic [ARB_QUANTUM_W-1:0] r_cnt;
  logic                     r_clr_pend;
  logic [NUM_INPUTS-1:0]    r_mask;
  logic [ARB_QUANTUM_W-1:0] r_quantum;
  logic [WIDTH-1:0]         r_tdata_hold;
  logic                     r_tlast_hold;

  logic [NUM_INPUTS-1:0]    w_eligible;
  logic [SW-1:0]            w_grant;
  logic                     w_any;
  logic                     w_pass;
  logic                     w_sel_valid;
  logic                     w_sel_last;
  logic [WIDTH-1:0]         w_sel_data;
  logic                     w_hs;
  logic                     w_eop;
  logic                     w_clr_any;
  logic [ARB_QUANTUM_W:0]   w_cnt_nxt;
  logic                     w_quantum_done;
  logic                     w_leave;
  logic                     w_unused_set;

  assign w_unused_set = &{1'b0, set_data[31:ARB_QUANTUM_W]};

  assign w_eligible  = i_tvalid & r_mask;
  assign w_pass      = (r_state == S_PASS);
  assign w_sel_valid = i_tvalid[r_src];
  assign w_sel_last  = i_tlast[r_src];
  assign w_sel_data  = i_tdata[r_src*WIDTH +: WIDTH];
  assign w_hs        = w_pass & w_sel_valid & o_tready;
  assign w_eop       = w_hs & w_sel_last;
  assign w_clr_any   = clear | r_clr_pend;

  // Mask and quantum are sampled only at the tlast handshake, so a write
  // landing mid-packet naturally takes effect at the next boundary.
  assign w_cnt_nxt      = {1'b0, r_cnt} + 1'b1;
  assign w_quantum_done = (w_cnt_nxt >= {1'b0, eff_quantum(r_quantum)});
  assign w_leave        = w_quantum_done | ~r_mask[r_src] | w_clr_any;

  rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .SW         (SW)
  ) u_rr_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_any      (w_any)
  );

  // Settings registers; clear deliberately leaves them untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask    <= '1;
      r_quantum <= ARB_QUANTUM_W'(1);
    end else if (set_stb) begin
      if (set_addr == A_MASK)  r_mask    <= set_data[NUM_INPUTS-1:0];
      if (set_addr == A_QUANT) r_quantum <= set_data[ARB_QUANTUM_W-1:0];
    end
  end

  // Arbitration FSM, grant pointer, packets-per-grant count, pending clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_ptr      <= LAST_IDX;
      r_cnt      <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clr_pend <= 1'b0;
          if (clear) begin
            r_ptr <= LAST_IDX;
            r_cnt <= '0;
          end else if (w_any) begin
            r_src   <= w_grant;
            r_ptr   <= w_grant;
            r_cnt   <= '0;
            r_state <= S_PASS;
          end
        end
        S_PASS: begin
          if (clear) r_clr_pend <= 1'b1;
          if (w_eop) begin
            if (w_leave) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              if (w_clr_any) begin
                r_ptr      <= LAST_IDX;
                r_clr_pend <= 1'b0;
              end
            end else begin
              r_cnt <= w_cnt_nxt[ARB_QUANTUM_W-1:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Remember the last presented beat so the FIFO side stays stable in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tdata_hold <= '0;
      r_tlast_hold <= 1'b0;
    end else if (w_pass) begin
      r_tdata_hold <= w_sel_data;
      r_tlast_hold <= w_sel_last;
    end
  end

  // Zero-latency pass-through of the granted input while in PASS
  always_comb begin
    o_tdata  = r_tdata_hold;
    o_tlast  = r_tlast_hold;
    o_tvalid = 1'b0;
    i_tready = '0;
    if (w_pass) begin
      o_tdata         = w_sel_data;
      o_tlast         = w_sel_last;
      o_tvalid        = w_sel_valid;
      i_tready[r_src] = o_tready;
    end
  end

  assign o_src = r_src;
  assign busy  = w_pass;

`ifdef NOC_FIFO_ARB_STATS_EN
  localparam logic [7:0] A_STATS = 8'(SR_ARB_BASE + ARB_STATS_OFS);

  logic [2:0]  r_stats_sel;
  logic [31:0] r_pkt_cnt  [NUM_INPUTS];
  logic [31:0] r_beat_cnt [NUM_INPUTS];

  // Readback selector; like the other settings it survives clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stats_sel <= '0;
    end else if (set_stb && (set_addr == A_STATS)) begin
      r_stats_sel <= set_data[2:0];
    end
  end

  // Per-input beat and packet counters; clear wipes them at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        r_pkt_cnt[k]  <= '0;
        r_beat_cnt[k] <= '0;
      end
    end else if (clear) begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        r_pkt_cnt[k]  <= '0;
        r_beat_cnt[k] <= '0;
      end
    end else if (w_hs) begin
      r_beat_cnt[r_src] <= r_beat_cnt[r_src] + 32'd1;
      if (w_sel_last) r_pkt_cnt[r_src] <= r_pkt_cnt[r_src] + 32'd1;
    end
  end

  // Selects beyond the last input read back as zero
  always_comb begin
    rb_data = '0;
    if (int'(r_stats_sel) < NUM_INPUTS)
      rb_data = {r_pkt_cnt[r_stats_sel[SW-1:0]], r_beat_cnt[r_stats_sel[SW-1:0]]};
  end
`endif

endmodule

// File: tb/tb_noc_fifo_pkt_arbiter.sv
// Directed bench for noc_fifo_pkt_arbiter with a beat scoreboard.
module tb_noc_fifo_pkt_arbiter;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         set_stb;
  logic [7:0]   set_addr;
  logic [31:0]  set_data;
  logic [127:0] i_tdata;
  logic [3:0]   i_tlast;
  logic [3:0]   i_tvalid;
  logic [3:0]   i_tready;
  logic [31:0]  o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready;
  logic [1:0]   o_src;
  logic         busy;
`ifdef NOC_FIFO_ARB_STATS_EN
  logic [63:0]  rb_data;
`endif

  noc_fifo_pkt_arbiter #(
    .NUM_INPUTS  (4),
    .WIDTH       (32),
    .SR_ARB_BASE (129)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .o_src    (o_src),
`ifdef NOC_FIFO_ARB_STATS_EN
    .rb_data  (rb_data),
`endif
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0]  gap;   // expected cycles since previous beat, 0 = unchecked
    logic [1:0]  src;
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [32:0] q0[$], q1[$], q2[$], q3[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_hs = 0;
  int hs_cnt  = 0;

  logic        req_wr, req_clr, rdy_toggle;
  logic [7:0]  req_addr;
  logic [31:0] req_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int k, input int p, input int b);
    return {8'(k), 8'(p), 16'(b)};
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [32:0] qfront(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  task automatic src_pkt(input int k, input int p, input int beats);
    for (int b = 0; b < beats; b++) begin
      logic [32:0] v;
      v = {(b == beats - 1), mk(k, p, b)};
      case (k)
        0: q0.push_back(v);
        1: q1.push_back(v);
        2: q2.push_back(v);
        default: q3.push_back(v);
      endcase
    end
  endtask

  task automatic exp_pkt(input int k, input int p, input int beats, input int g0, input int gin);
    for (int b = 0; b < beats; b++) begin
      exp_t e;
      e.gap  = (b == 0) ? 3'(g0) : 3'(gin);
      e.src  = 2'(k);
      e.last = (b == beats - 1);
      e.data = mk(k, p, b);
      sb.push_back(e);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      if (qsize(k) > 0) begin
        logic [32:0] v;
        v = qfront(k);
        i_tvalid[k]          = 1'b1;
        i_tlast[k]           = v[32];
        i_tdata[k*32 +: 32]  = v[31:0];
      end else begin
        i_tvalid[k]          = 1'b0;
        i_tlast[k]           = 1'b0;
        i_tdata[k*32 +: 32]  = '0;
      end
    end
    o_tready = rdy_toggle ? ~cyc[0] : 1'b1;
    set_stb  = req_wr;
    set_addr = req_addr;
    set_data = req_data;
    clear    = req_clr;
    req_wr   = 1'b0;
    req_clr  = 1'b0;
  endtask

  // One clock: check the beat accepted at the coming edge, then redrive
  task automatic step();
    @(negedge clk);
    if (o_tvalid && o_tready) begin
      hs_cnt++;
      chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("o_src", 64'(o_src), 64'(e.src));
        chk("o_tdata", 64'(o_tdata), 64'(e.data));
        chk("o_tlast", 64'(o_tlast), 64'(e.last));
        chk("i_tready", 64'(i_tready), 64'(4'b0001 << e.src));
        if (e.gap != 0) chk("beat_gap", 64'(cyc - last_hs), 64'(e.gap));
      end
      last_hs = cyc;
    end
    for (int k = 0; k < 4; k++)
      if (i_tvalid[k] && i_tready[k]) qpop(k);
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while (sb.size() > 0 && n < limit) begin
      step();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_hs(input string tag, input int n, input int limit);
    int c;
    c = 0;
    while (hs_cnt < n && c < limit) begin
      step();
      c++;
    end
    chk(tag, 64'(hs_cnt >= n), 64'd1);
  endtask

  task automatic wr(input int ofs, input logic [31:0] d);
    req_wr   = 1'b1;
    req_addr = 8'(129 + ofs);
    req_data = d;
    steps(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    sb.delete();
    req_wr = 1'b0; req_clr = 1'b0; req_addr = '0; req_data = '0;
    rdy_toggle = 1'b0;
    drive();
    @(negedge clk);
    chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_i_tready", 64'(i_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_o_src", 64'(o_src), 64'd0);
    chk("rst_o_tdata", 64'(o_tdata), 64'd0);
    chk("rst_o_tlast", 64'(o_tlast), 64'd0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    cyc     = 0;
    last_hs = 0;
    hs_cnt  = 0;
    drive();
  endtask

  initial begin
    reset = 1'b1;
    i_tdata = '0; i_tlast = '0; i_tvalid = '0; o_tready = 1'b1;
    set_stb = 1'b0; set_addr = '0; set_data = '0; clear = 1'b0;

    // Round-robin across four inputs, quantum 1, one bubble per packet
    do_reset();
    src_pkt(0, 0, 2); src_pkt(0, 1, 2);
    src_pkt(1, 0, 2); src_pkt(2, 0, 2); src_pkt(3, 0, 2);
    exp_pkt(0, 0, 2, 0, 1);
    exp_pkt(1, 0, 2, 2, 1);
    exp_pkt(2, 0, 2, 2, 1);
    exp_pkt(3, 0, 2, 2, 1);
    exp_pkt(0, 1, 2, 2, 1);
    drain("t1_drain", 100);

    // Quantum 3 with inputs 1 and 2: back-to-back within a grant
    do_reset();
    wr(1, 32'd3);
    for (int p = 0; p < 5; p++) begin
      src_pkt(1, p, 1);
      src_pkt(2, p, 1);
    end
    exp_pkt(1, 0, 1, 0, 1); exp_pkt(1, 1, 1, 1, 1); exp_pkt(1, 2, 1, 1, 1);
    exp_pkt(2, 0, 1, 2, 1); exp_pkt(2, 1, 1, 1, 1); exp_pkt(2, 2, 1, 1, 1);
    exp_pkt(1, 3, 1, 2, 1); exp_pkt(1, 4, 1, 1, 1);
    drain("t2_drain", 100);
    steps(5);
    chk("t2_waits_in_pass", 64'(busy), 64'd1);
    chk("t2_in2_left", 64'(qsize(2)), 64'd2);

    // Backpressure during a long packet; no interleave from input 3
    do_reset();
    rdy_toggle = 1'b1;
    src_pkt(0, 0, 16); src_pkt(3, 0, 2);
    exp_pkt(0, 0, 16, 0, 0);
    exp_pkt(3, 0, 2, 0, 0);
    drain("t3_drain", 200);

    // Mask out input 0 mid-packet: packet completes, never granted again
    do_reset();
    wr(1, 32'd4);
    src_pkt(0, 0, 4); src_pkt(0, 1, 4); src_pkt(0, 2, 4);
    for (int p = 0; p < 4; p++) src_pkt(1, p, 1);
    exp_pkt(0, 0, 4, 0, 1);
    for (int p = 0; p < 4; p++) exp_pkt(1, p, 1, (p == 0) ? 2 : 1, 1);
    wait_hs("t4_first_beat", 1, 20);
    wr(0, 32'hE);
    drain("t4_drain", 100);
    steps(20);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_in0_untouched", 64'(qsize(0)), 64'd8);

    // Clear mid-packet: whole packet delivered, pointer restarts at input 0
    do_reset();
    src_pkt(2, 0, 4);
    exp_pkt(2, 0, 4, 0, 1);
    wait_hs("t5_first_beat", 1, 20);
    src_pkt(0, 0, 1); src_pkt(3, 0, 1);
    exp_pkt(0, 0, 1, 2, 1);
    exp_pkt(3, 0, 1, 2, 1);
    req_clr = 1'b1;
    drain("t5_drain", 100);

    // Quantum written as 0 acts as 1
    do_reset();
    wr(1, 32'd0);
    src_pkt(0, 0, 1); src_pkt(0, 1, 1); src_pkt(1, 0, 1);
    exp_pkt(0, 0, 1, 0, 1);
    exp_pkt(1, 0, 1, 2, 1);
    exp_pkt(0, 1, 1, 2, 1);
    drain("t6_drain", 100);

    // Mask 0 parks in IDLE; a write alongside clear still lands
    do_reset();
    wr(0, 32'h0);
    src_pkt(0, 0, 2); src_pkt(1, 0, 1);
    steps(10);
    chk("t7_mask0_idle", 64'(busy), 64'd0);
    chk("t7_mask0_held", 64'(qsize(0)), 64'd2);
    exp_pkt(0, 0, 2, 0, 1);
    req_clr = 1'b1;
    wr(0, 32'h1);
    drain("t7_drain", 50);
    steps(10);
    chk("t7_idle_after", 64'(busy), 64'd0);
    chk("t7_in1_masked", 64'(qsize(1)), 64'd1);

`ifdef NOC_FIFO_ARB_STATS_EN
    // Statistics for input 1: 3 packets, 15 beats, then clear
    do_reset();
    wr(2, 32'd1);
    for (int p = 0; p < 3; p++) begin
      src_pkt(1, p, 5);
      exp_pkt(1, p, 5, (p == 0) ? 0 : 2, 1);
    end
    drain("t8_drain", 100);
    steps(2);
    chk("t8_rb_data", rb_data, {32'd3, 32'd15});
    req_clr = 1'b1;
    steps(2);
    chk("t8_rb_cleared", rb_data, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
